// File: rtl/ef_sms_pkg.sv
// Shared types and constants for the ef_sms_tree8 mismatch-shaping selector.
// Optional feature macro used by the block: SMS_DITHER_EN.
package ef_sms_pkg;

  // Tree geometry: eight unit elements driven by seven switching blocks.
  localparam int N_ELEM = 8;
  localparam int N_SB   = 7;
  localparam int CODE_W = 4;

  // Largest legal element count; anything above is clipped to this.
  localparam logic [CODE_W-1:0] CODE_MAX = 4'd8;

  // Switching-block state: accumulated imbalance between its two halves.
  typedef logic signed [1:0] sb_state_t;

  localparam sb_state_t SB_ZERO = 2'sb00;
  localparam sb_state_t SB_POS  = 2'sb01;
  localparam sb_state_t SB_NEG  = 2'sb11;

  // Direction of the odd leftover element in one switching block.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,  // even count, split evenly
    STEP_UP   = 2'b01,  // leftover goes to the top (higher-index) half
    STEP_DOWN = 2'b10   // leftover goes to the bottom half
  } sb_step_e;

  // State after applying one step; the encoding 2'b10 is never reached
  // normally and is steered back to zero.
  function automatic sb_state_t sb_apply(input sb_state_t st, input sb_step_e step);
    sb_state_t nxt;
    nxt = SB_ZERO;
    if (st == 2'sb10) begin
      nxt = SB_ZERO;
    end else begin
      case (step)
        STEP_UP:   nxt = (st == SB_NEG) ? SB_ZERO : SB_POS;
        STEP_DOWN: nxt = (st == SB_POS) ? SB_ZERO : SB_NEG;
        STEP_NONE: nxt = st;
        default:   nxt = SB_ZERO;
      endcase
    end
    return nxt;
  endfunction

  // Saturate an incoming code to the number of elements.
  function automatic logic [CODE_W-1:0] clip_code(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] res;
    if (code > CODE_MAX) begin
      res = CODE_MAX;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/ef_sms_sb.sv
// One switching block of the mismatch-shaping tree: splits a count into a
// top and bottom half, steering an odd leftover so its own imbalance stays
// in {-1,0,+1}. With SMS_DITHER_EN the zero-state choice follows i_r.
module ef_sms_sb
  import ef_sms_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_en,
  input  logic [W-1:0] i_c,
  input  logic         i_r,
  output logic [W-2:0] o_top,
  output logic [W-2:0] o_bot
);

  sb_state_t  st_q;
  sb_state_t  st_d;
  sb_step_e   step_s;
  sb_step_e   zero_step_s;
  logic       odd_s;
  logic [W-2:0] half_s;
  logic [W-2:0] half_up_s;

  assign odd_s     = i_c[0];
  assign half_s    = i_c[W-1:1];
  assign half_up_s = half_s + (W-1)'(1);

`ifdef SMS_DITHER_EN
  // Random tie-break at zero state breaks up idle tones.
  assign zero_step_s = i_r ? STEP_UP : STEP_DOWN;
`else
  // Deterministic tie-break: leftover goes to the top half.
  assign zero_step_s = STEP_UP;
  logic unused_r;
  assign unused_r = i_r;
`endif

  // Pick where the odd leftover goes based on the current imbalance.
  always_comb begin
    step_s = STEP_NONE;
    if (!odd_s) begin
      step_s = STEP_NONE;
    end else begin
      case (st_q)
        SB_POS:  step_s = STEP_DOWN;
        SB_NEG:  step_s = STEP_UP;
        SB_ZERO: step_s = zero_step_s;
        default: step_s = STEP_NONE;
      endcase
    end
  end

  // Split the count: the half receiving the leftover gets one more.
  always_comb begin
    o_top = half_s;
    o_bot = half_s;
    case (step_s)
      STEP_UP: begin
        o_top = half_up_s;
        o_bot = half_s;
      end
      STEP_DOWN: begin
        o_top = half_s;
        o_bot = half_up_s;
      end
      default: begin
        o_top = half_s;
        o_bot = half_s;
      end
    endcase
  end

  // Next imbalance, held when the update enable is low.
  always_comb begin
    st_d = st_q;
    if (i_en) begin
      st_d = sb_apply(st_q, step_s);
    end else begin
      st_d = st_q;
    end
  end

  // Imbalance state register.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      st_q <= SB_ZERO;
    end else begin
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/ef_sms_tree8.sv
// Mismatch-shaping element selector for an 8-element DAC segment: a
// three-layer binary tree of switching blocks turns a count 0..8 into eight
// registered element enables with first-order shaped mismatch error.
// Optional feature macro: SMS_DITHER_EN (random zero-state tie-break).
module ef_sms_tree8
  import ef_sms_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_b,
  input  logic              i_en,
  input  logic [CODE_W-1:0] i_code,
  input  logic [N_SB:0]     i_r,
  output logic [N_ELEM-1:0] o_elem,
  output logic              o_clip
);

  logic [CODE_W-1:0] code_c_s;
  logic              over_s;
  logic [2:0]        sb0_top_s;
  logic [2:0]        sb0_bot_s;
  logic [1:0]        sb1_top_s;
  logic [1:0]        sb1_bot_s;
  logic [1:0]        sb2_top_s;
  logic [1:0]        sb2_bot_s;
  logic [N_ELEM-1:0] tree_elem_s;

  logic [N_ELEM-1:0] elem_q;
  logic [N_ELEM-1:0] elem_d;
  logic              clip_q;
  logic              clip_d;

  // The LFSR provides eight bits but only seven blocks consume one.
  logic unused_r7;
  assign unused_r7 = i_r[N_SB];

  assign over_s   = (i_code > CODE_MAX);
  assign code_c_s = clip_code(i_code);

  // Layer 0: whole code split into upper and lower nibble of elements.
  ef_sms_sb #(.W(4)) u_sb0 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(code_c_s), .i_r(i_r[0]),
    .o_top(sb0_top_s), .o_bot(sb0_bot_s)
  );

  // Layer 1: each nibble split into element pairs.
  ef_sms_sb #(.W(3)) u_sb1 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb0_top_s), .i_r(i_r[1]),
    .o_top(sb1_top_s), .o_bot(sb1_bot_s)
  );

  ef_sms_sb #(.W(3)) u_sb2 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb0_bot_s), .i_r(i_r[2]),
    .o_top(sb2_top_s), .o_bot(sb2_bot_s)
  );

  // Layer 2: each pair split into single elements.
  ef_sms_sb #(.W(2)) u_sb3 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb1_top_s), .i_r(i_r[3]),
    .o_top(tree_elem_s[7:7]), .o_bot(tree_elem_s[6:6])
  );

  ef_sms_sb #(.W(2)) u_sb4 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb1_bot_s), .i_r(i_r[4]),
    .o_top(tree_elem_s[5:5]), .o_bot(tree_elem_s[4:4])
  );

  ef_sms_sb #(.W(2)) u_sb5 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb2_top_s), .i_r(i_r[5]),
    .o_top(tree_elem_s[3:3]), .o_bot(tree_elem_s[2:2])
  );

  ef_sms_sb #(.W(2)) u_sb6 (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_c(sb2_bot_s), .i_r(i_r[6]),
    .o_top(tree_elem_s[1:1]), .o_bot(tree_elem_s[0:0])
  );

  // Next output and sticky clip flag; everything holds while disabled.
  always_comb begin
    elem_d = elem_q;
    clip_d = clip_q;
    if (i_en) begin
      elem_d = tree_elem_s;
      clip_d = clip_q | over_s;
    end else begin
      elem_d = elem_q;
      clip_d = clip_q;
    end
  end

  // Output and clip registers.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      elem_q <= 8'h00;
      clip_q <= 1'b0;
    end else begin
      elem_q <= elem_d;
      clip_q <= clip_d;
    end
  end

  assign o_elem = elem_q;
  assign o_clip = clip_q;

endmodule

// File: tb/tb_ef_sms_tree8.sv
// Self-checking bench for ef_sms_tree8 with a count-splitting reference model.
module tb_ef_sms_tree8;

  logic       i_clk = 1'b0;
  logic       i_rst_b;
  logic       i_en;
  logic [3:0] i_code;
  logic [7:0] i_r;
  logic [7:0] o_elem;
  logic       o_clip;

  int checks   = 0;
  int failures = 0;

  // Reference model state: signed imbalance per block, outputs.
  int         st_m [7];
  logic [7:0] elem_m;
  logic       clip_m;
  logic [7:0] lfsr = 8'hA5;

  ef_sms_tree8 dut (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_en(i_en),
    .i_code(i_code), .i_r(i_r), .o_elem(o_elem), .o_clip(o_clip)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) st_m[k] = 0;
    elem_m = 8'h00;
    clip_m = 1'b0;
  endtask

  // Count-level model: node k splits cnt[k] to nodes 2k+1 (top) and 2k+2.
  task automatic model_step(input logic en, input int code, input logic [7:0] r);
    int cnt [7];
    int c, s, top, bot, idx;
    logic [7:0] e;
    if (en) begin
      if (code > 8) clip_m = 1'b1;
      cnt[0] = (code > 8) ? 8 : code;
      e = 8'h00;
      for (int k = 0; k < 7; k++) begin
        c = cnt[k];
        if (c % 2 == 0) s = 0;
        else if (st_m[k] > 0) s = -1;
        else if (st_m[k] < 0) s = 1;
        else begin
`ifdef SMS_DITHER_EN
          s = r[k] ? 1 : -1;
`else
          s = 1;
`endif
        end
        top = (c + s) / 2;
        bot = (c - s) / 2;
        st_m[k] = st_m[k] + s;
        if (k < 3) begin
          cnt[2*k+1] = top;
          cnt[2*k+2] = bot;
        end else begin
          idx = 7 - 2*(k-3);
          e[idx]   = (top == 1);
          e[idx-1] = (bot == 1);
        end
      end
      elem_m = e;
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare just after it.
  task automatic cycle(input logic en, input logic [3:0] code, input logic [7:0] r);
    i_en = en; i_code = code; i_r = r;
    @(posedge i_clk);
    if (i_rst_b) model_step(en, int'(code), r);
    #1;
    chk("elem", o_elem, elem_m);
    chk("clip", o_clip, clip_m);
  endtask

  initial begin
    logic [7:0] seq1 [4];
    logic [7:0] held;
    int use_cnt [8];
    int mx, mn;
    seq1[0] = 8'h80; seq1[1] = 8'h08; seq1[2] = 8'h20; seq1[3] = 8'h02;

    // Reset held with enable and a code applied.
    i_rst_b = 1'b0; i_en = 1'b1; i_code = 4'd5; i_r = 8'h00;
    model_reset();
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("rst_elem", o_elem, 8'h00);
      chk("rst_clip", o_clip, 1'b0);
    end
    i_rst_b = 1'b1;
    cycle(1'b1, 4'd5, 8'h00);
    chk("pop5", $countones(o_elem), 5);
`ifndef SMS_DITHER_EN
    chk("first5", o_elem, 8'hEA);
`endif

    // Asynchronous reset mid-stream, then code 1 walk.
    #2; i_rst_b = 1'b0; #1;
    chk("async_elem", o_elem, 8'h00);
    model_reset();
    @(posedge i_clk); #1; i_rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'd1, 8'h00);
`ifndef SMS_DITHER_EN
      chk("walk1", o_elem, seq1[i]);
`endif
    end

    // Full and empty codes leave the states alone.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'd8, 8'h5A);
      chk("full", o_elem, 8'hFF);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd0, 8'hC3);
      chk("empty", o_elem, 8'h00);
    end
    cycle(1'b1, 4'd1, 8'h00);
    cycle(1'b1, 4'd3, 8'h00);

    // Enable low: outputs and states frozen, over-range code ignored.
    held = elem_m;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'($urandom_range(0, 9)), 8'($urandom));
      chk("freeze", o_elem, held);
    end
    cycle(1'b0, 4'd9, 8'h00);
    chk("no_clip_dis", o_clip, 1'b0);
    cycle(1'b1, 4'd1, 8'h00);
    cycle(1'b1, 4'd5, 8'h00);

    // Over-range code clips to 8 and sets the sticky flag.
    cycle(1'b1, 4'd9, 8'h00);
    chk("clip_elem", o_elem, 8'hFF);
    chk("clip_set", o_clip, 1'b1);
    cycle(1'b1, 4'd3, 8'h00);
    chk("clip_stay", o_clip, 1'b1);
    chk("pop3", $countones(o_elem), 3);

    // Random codes, enables and LFSR bits against the model.
    for (int i = 0; i < 3000; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      cycle(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 10)), lfsr);
    end

    // Constant code 3: element usage stays balanced.
    for (int k = 0; k < 8; k++) use_cnt[k] = 0;
    for (int i = 0; i < 400; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      cycle(1'b1, 4'd3, lfsr);
      for (int k = 0; k < 8; k++) use_cnt[k] += int'(o_elem[k]);
    end
    mx = use_cnt[0]; mn = use_cnt[0];
    for (int k = 1; k < 8; k++) begin
      if (use_cnt[k] > mx) mx = use_cnt[k];
      if (use_cnt[k] < mn) mn = use_cnt[k];
    end
    chk("usage_spread", ((mx - mn) <= 2), 1'b1);
    chk("usage_total", mx + mn > 0, 1'b1);

    // Final asynchronous reset clears the sticky flag.
    #2; i_rst_b = 1'b0; #1;
    chk("final_elem", o_elem, 8'h00);
    chk("final_clip", o_clip, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
